mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs (ALUResultM, WriteDataM, WA3M, PCSrcM, RegWriteM, MemWriteM, MemtoRegM).
- Issues word accesses to the data-memory bus over a req/ack handshake.
- Stalls the pipeline while an access is outstanding, then loads the MEM/WB register that feeds writeback.
- Reports misaligned and timed-out accesses.

Parameters:
- WIDTH, 32, datapath/address width.
- TIMEOUT, 16, maximum BUSY cycles without bus_ack before the access is aborted (>=2).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ALUResultM  input  WIDTH  memory address or ALU result from EX/MEM.
- WriteDataM  input  WIDTH  store data.
- WA3M  input  4  destination register.
- PCSrcM  input  1  PC-write indication.
- RegWriteM  input  1  register-write enable.
- MemWriteM  input  1  store.
- MemtoRegM  input  1  load.
- bus_ack  input  1  memory completes the access this cycle.
- bus_rdata  input  WIDTH  load data, valid when bus_ack=1.
- bus_req  output  1  access request (registered).
- bus_we  output  1  1=write, 0=read (registered).
- bus_addr  output  WIDTH  word-aligned address (registered).
- bus_wdata  output  WIDTH  store data (registered).
- stallM  output  1  combinational; holds EX/MEM and earlier stages.
- PCSrcW, RegWriteW, MemtoRegW  output  1 each  MEM/WB control.
- WA3W  output  4  MEM/WB destination.
- ALUOutW  output  WIDTH  MEM/WB ALU result.
- ReadDataW  output  WIDTH  MEM/WB load data.
- bus_err  output  1  sticky error flag.

Behaviour:
- Reset values: every registered output and bus_err are 0; state IDLE; timeout counter 0. Reset acts immediately, including mid-access: bus_req drops without waiting for a clock.
- memop = MemWriteM | MemtoRegM. misaligned = memop & (ALUResultM[1:0] != 0).
- States:
  - IDLE
    - memop & !misaligned: load bus_addr={ALUResultM[WIDTH-1:2],2'b00}, bus_wdata=WriteDataM, bus_we=MemWriteM; set bus_req=1; go to BUSY.
    - misaligned: no bus access, set bus_err, retire as bubble.
    - Otherwise: retire the instruction normally.
  - BUSY
    - bus_req, bus_addr, bus_we and bus_wdata stay stable until exit.
    - Counter increments each cycle.
    - bus_ack=1: retire the instruction, clear bus_req and the counter, go to IDLE.
    - Counter reaches TIMEOUT-1 without ack: abort, set bus_err, retire as bubble, go to IDLE.
    - bus_ack in the same cycle as the timeout limit: ack wins, no error.
- stallM = (IDLE & memop & !misaligned) | (BUSY & !bus_ack & !timeout_hit). It is low in the retiring cycle, so EX/MEM advances on that edge.
- MEM/WB register:
  - Updates every edge.
  - Retire: PCSrcW, RegWriteW, MemtoRegW, WA3W and ALUOutW take the M values. ReadDataW = bus_rdata for a read, 0 for a write or non-memop.
  - While stallM=1: loads a bubble (PCSrcW=RegWriteW=MemtoRegW=0; other fields unchanged).
  - Bubble retire (misaligned or timeout): control bits 0, ReadDataW=0.
- MemWriteM and MemtoRegM both 1: treated as a write; ReadDataW=0; MemtoRegW passes through.
- bus_ack seen in IDLE is ignored.
- Latency:
  - Non-memop: W outputs valid 1 edge after M inputs.
  - Memop: 1 (IDLE to BUSY) + N cycles, where bus_ack arrives in the Nth BUSY cycle.
- bus_err remains set until reset.

Test Plan:
- Non-memop: ALUResultM=0x0000_0010, RegWriteM=1, WA3M=3 -> next edge ALUOutW=0x10, RegWriteW=1, WA3W=3; stallM stays 0; bus_req never rises.
- Load: ALUResultM=0x100, MemtoRegM=1, bus_ack 3 cycles after bus_req, bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_we=0; stallM high 3 cycles; then ReadDataW=0xDEADBEEF, MemtoRegW=1; exactly one non-bubble W update.
- Store: ALUResultM=0x204, WriteDataM=0x12345678, MemWriteM=1, ack after 1 cycle -> bus_we=1, bus_wdata=0x12345678; ReadDataW=0; bubbles during stall.
- Misaligned: MemtoRegM=1, ALUResultM=0x102 -> no bus_req, bus_err=1 and sticky, W bubble, no stall.
- Timeout/tie (TIMEOUT=16):
  - No ack -> bus_req drops after 16 BUSY cycles, bus_err=1, RegWriteW=0.
  - Rerun with ack exactly on cycle 16 -> normal retire, bus_err stays 0.
- Reset mid-access: assert reset in BUSY cycle 2 -> bus_req, stallM and all W outputs 0 immediately; after release, a new load completes normally.

Source files
------------

// File: rtl/mem_stage_access.sv
// Memory stage: issues word accesses over a req/ack bus, stalls the pipeline
// while an access is outstanding, and loads the MEM/WB register for writeback.
module mem_stage_access #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [3:0]       WA3M,
    input  logic             PCSrcM,
    input  logic             RegWriteM,
    input  logic             MemWriteM,
    input  logic             MemtoRegM,
    input  logic             bus_ack,
    input  logic [WIDTH-1:0] bus_rdata,
    output logic             bus_req,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    output logic             stallM,
    output logic             PCSrcW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [3:0]       WA3W,
    output logic [WIDTH-1:0] ALUOutW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic             bus_err
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_t;

    state_t           r_state, w_state_d;
    logic [CW-1:0]    r_cnt, w_cnt_d;
    logic             r_bus_req, w_bus_req_d;
    logic             r_bus_we, w_bus_we_d;
    logic [WIDTH-1:0] r_bus_addr, w_bus_addr_d;
    logic [WIDTH-1:0] r_bus_wdata, w_bus_wdata_d;
    logic             r_err, w_err_d;

    logic             w_memop;
    logic             w_misaligned;
    logic             w_idle;
    logic             w_busy;
    logic             w_timeout_hit;
    logic             w_start;
    logic             w_abort;
    logic             w_stall;
    logic             w_bubble;
    logic             w_is_read;

    // Decode the incoming instruction and the access-progress conditions
    always_comb begin
        w_memop       = MemWriteM | MemtoRegM;
        w_misaligned  = w_memop & (ALUResultM[1:0] != 2'b00);
        w_idle        = (r_state == StIdle);
        w_busy        = (r_state == StBusy);
        w_timeout_hit = w_busy & (r_cnt == CW'(TIMEOUT - 1));
        w_start       = w_idle & w_memop & ~w_misaligned;
        // An ack on the limit cycle wins over the timeout
        w_abort       = w_timeout_hit & ~bus_ack;
        w_stall       = w_start | (w_busy & ~bus_ack & ~w_timeout_hit);
        w_bubble      = (w_idle & w_misaligned) | w_abort;
        // Both store and load set counts as a store
        w_is_read     = MemtoRegM & ~MemWriteM;
    end

    // Next-state logic for the access FSM and the registered bus interface
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_bus_req_d   = r_bus_req;
        w_bus_we_d    = r_bus_we;
        w_bus_addr_d  = r_bus_addr;
        w_bus_wdata_d = r_bus_wdata;
        w_err_d       = r_err | w_bubble;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d     = StBusy;
                    w_cnt_d       = '0;
                    w_bus_req_d   = 1'b1;
                    w_bus_we_d    = MemWriteM;
                    w_bus_addr_d  = {ALUResultM[WIDTH-1:2], 2'b00};
                    w_bus_wdata_d = WriteDataM;
                end
            end
            StBusy: begin
                if (bus_ack || w_timeout_hit) begin
                    w_state_d   = StIdle;
                    w_cnt_d     = '0;
                    w_bus_req_d = 1'b0;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_d   = StIdle;
                w_cnt_d     = '0;
                w_bus_req_d = 1'b0;
            end
        endcase
    end

    // FSM state, counter, bus request registers and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_bus_req   <= w_bus_req_d;
            r_bus_we    <= w_bus_we_d;
            r_bus_addr  <= w_bus_addr_d;
            r_bus_wdata <= w_bus_wdata_d;
            r_err       <= w_err_d;
        end
    end

    // MEM/WB register: bubble while stalled, bubble on aborted retire, else pass through
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            WA3W      <= '0;
            ALUOutW   <= '0;
            ReadDataW <= '0;
        end else if (w_stall) begin
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else if (w_bubble) begin
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            WA3W      <= WA3M;
            ALUOutW   <= ALUResultM;
            ReadDataW <= '0;
        end else begin
            PCSrcW    <= PCSrcM;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            WA3W      <= WA3M;
            ALUOutW   <= ALUResultM;
            ReadDataW <= w_is_read ? bus_rdata : '0;
        end
    end

    // Stall is masked by reset so the pipeline is released immediately
    assign stallM    = w_stall & ~reset;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_err   = r_err;

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: vector table plus scoreboard queue.
module tb_mem_stage_access;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  WA3M;
    logic        PCSrcM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        MemtoRegM;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        stallM;
    logic        PCSrcW;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [3:0]  WA3W;
    logic [31:0] ALUOutW;
    logic [31:0] ReadDataW;
    logic        bus_err;

    mem_stage_access #(
        .WIDTH  (32),
        .TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .WA3M      (WA3M),
        .PCSrcM    (PCSrcM),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM),
        .MemtoRegM (MemtoRegM),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .stallM    (stallM),
        .PCSrcW    (PCSrcW),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .WA3W      (WA3W),
        .ALUOutW   (ALUOutW),
        .ReadDataW (ReadDataW),
        .bus_err   (bus_err)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  wa3;
        logic        pc;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        ack_idle;
        int          ack_at;     // BUSY cycle carrying bus_ack, 0 = never
        logic [31:0] rdata;
        logic [2:0]  exp_ctrl;   // {PCSrcW, RegWriteW, MemtoRegW}
        logic [31:0] exp_rd;
        int          exp_stall;
        logic        exp_err;
        logic        chk_bus;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic [2:0]  ctrl;
        logic [3:0]  wa3;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        full;
    } exp_t;

    exp_t q[$];
    int   n_err = 0;
    int   n_chk = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] wd,
                                input logic [3:0] wa3, input logic pc, input logic rw,
                                input logic mw, input logic m2r, input logic ack_idle,
                                input int ack_at, input logic [31:0] rdata,
                                input logic [2:0] exp_ctrl, input logic [31:0] exp_rd,
                                input int exp_stall, input logic exp_err,
                                input logic chk_bus, input logic exp_we);
        vec_t v;
        v.alu = alu; v.wd = wd; v.wa3 = wa3; v.pc = pc; v.rw = rw; v.mw = mw; v.m2r = m2r;
        v.ack_idle = ack_idle; v.ack_at = ack_at; v.rdata = rdata;
        v.exp_ctrl = exp_ctrl; v.exp_rd = exp_rd; v.exp_stall = exp_stall;
        v.exp_err = exp_err; v.chk_bus = chk_bus; v.exp_we = exp_we;
        return v;
    endfunction

    task automatic set_nop();
        ALUResultM = '0; WriteDataM = '0; WA3M = '0;
        PCSrcM = 0; RegWriteM = 0; MemWriteM = 0; MemtoRegM = 0;
        bus_ack = 0; bus_rdata = '0;
    endtask

    // Entered and left at posedge+1; drives one instruction until it retires.
    task automatic run_op(input vec_t v, input string name);
        exp_t e;
        exp_t g;
        int   stall_n;
        bit   done;
        logic st;
        ALUResultM = v.alu; WriteDataM = v.wd; WA3M = v.wa3;
        PCSrcM = v.pc; RegWriteM = v.rw; MemWriteM = v.mw; MemtoRegM = v.m2r;
        e.ctrl = v.exp_ctrl; e.wa3 = v.wa3; e.alu = v.alu; e.rd = v.exp_rd;
        e.full = (v.exp_ctrl != 3'b000);
        q.push_back(e);
        stall_n = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            bus_ack   = (k == 0) ? v.ack_idle : (v.ack_at != 0 && k == v.ack_at);
            bus_rdata = v.rdata;
            #1;
            if (k == 1 && v.chk_bus) begin
                chk({name, " bus_req"}, 32'(bus_req), 32'd1);
                chk({name, " bus_addr"}, bus_addr, v.alu);
                chk({name, " bus_we"}, 32'(bus_we), 32'(v.exp_we));
                if (v.exp_we) chk({name, " bus_wdata"}, bus_wdata, v.wd);
            end
            st = stallM;
            if (st) stall_n++;
            @(posedge clk);
            #1;
            if (!st) begin
                g = q.pop_front();
                chk({name, " W ctrl"}, 32'({PCSrcW, RegWriteW, MemtoRegW}), 32'(g.ctrl));
                chk({name, " ReadDataW"}, ReadDataW, g.rd);
                if (g.full) begin
                    chk({name, " WA3W"}, 32'(WA3W), 32'(g.wa3));
                    chk({name, " ALUOutW"}, ALUOutW, g.alu);
                end
                done = 1;
            end else begin
                chk({name, " stall bubble"}, 32'({PCSrcW, RegWriteW, MemtoRegW}), 32'd0);
            end
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL %s retire: got none expected retire within 40 cycles", name);
            q.delete();
        end
        set_nop();
        chk({name, " stall cycles"}, 32'(stall_n), 32'(v.exp_stall));
        chk({name, " bus_req after"}, 32'(bus_req), 32'd0);
        chk({name, " bus_err"}, 32'(bus_err), 32'(v.exp_err));
    endtask

    vec_t vecs[8];
    vec_t post;

    initial begin
        // alu, wd, wa3, pc, rw, mw, m2r, ack_idle, ack_at, rdata,
        // exp_ctrl, exp_rd, exp_stall, exp_err, chk_bus, exp_we
        vecs[0] = mk(32'h10, 0, 4'd3, 0, 1, 0, 0, 0, 0, 0,
                     3'b010, 0, 0, 0, 0, 0);
        vecs[1] = mk(32'h100, 0, 4'd5, 0, 1, 0, 1, 0, 3, 32'hDEADBEEF,
                     3'b011, 32'hDEADBEEF, 3, 0, 1, 0);
        vecs[2] = mk(32'h204, 32'h12345678, 4'd6, 0, 0, 1, 0, 0, 1, 32'h11111111,
                     3'b000, 0, 1, 0, 1, 1);
        vecs[3] = mk(32'h40, 32'hCAFE0001, 4'd7, 1, 1, 1, 1, 0, 2, 32'hAAAA5555,
                     3'b111, 0, 2, 0, 1, 1);
        vecs[4] = mk(32'h80, 0, 4'd8, 0, 1, 0, 1, 0, 16, 32'h55,
                     3'b011, 32'h55, 16, 0, 1, 0);
        vecs[5] = mk(32'h84, 0, 4'd2, 0, 1, 0, 1, 0, 0, 32'h77,
                     3'b000, 0, 16, 1, 1, 0);
        vecs[6] = mk(32'h102, 0, 4'd4, 0, 1, 0, 1, 0, 0, 32'h88,
                     3'b000, 0, 0, 1, 0, 0);
        vecs[7] = mk(32'hFFFFFFFC, 0, 4'd15, 1, 0, 0, 0, 1, 0, 32'h999,
                     3'b100, 0, 0, 1, 0, 0);
        post    = mk(32'h1F0, 0, 4'd9, 0, 1, 0, 1, 0, 2, 32'h0BADF00D,
                     3'b011, 32'h0BADF00D, 2, 0, 1, 0);

        reset = 1'b1;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        chk("reset bus_req", 32'(bus_req), 32'd0);
        chk("reset stallM", 32'(stallM), 32'd0);
        chk("reset W ctrl", 32'({PCSrcW, RegWriteW, MemtoRegW}), 32'd0);
        chk("reset ALUOutW", ALUOutW, 32'd0);
        chk("reset bus_err", 32'(bus_err), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted in the second BUSY cycle of a load
        ALUResultM = 32'h300; MemtoRegM = 1; RegWriteM = 1; WA3M = 4'd12;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("midrst bus_req before", 32'(bus_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst bus_req", 32'(bus_req), 32'd0);
        chk("midrst stallM", 32'(stallM), 32'd0);
        chk("midrst W ctrl", 32'({PCSrcW, RegWriteW, MemtoRegW}), 32'd0);
        chk("midrst WA3W", 32'(WA3W), 32'd0);
        chk("midrst ALUOutW", ALUOutW, 32'd0);
        chk("midrst ReadDataW", ReadDataW, 32'd0);
        chk("midrst bus_err", 32'(bus_err), 32'd0);
        set_nop();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op(post, "postrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
